// File: rtl/fifo_pkg.sv
// Purpose: shared constants and helpers for the parameterised synchronous FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // One extra MSB beyond the address width lets full and empty be told
  // apart when both pointers land on the same slot after a wrap.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Purpose: DEPTH x DATA_WIDTH register array, one write port, one async read port.
// Latency: write lands on the clock edge; read data is combinational from raddr.
// Backpressure: none; the caller decides when a write is allowed.
//
// Ports: clk (rising-edge clock), we/waddr/wdata (write port),
//        raddr/rdata (asynchronous read port). Contents are not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Purpose: single-clock FIFO with thresholds, sticky error flags and optional FWFT.
// Latency: FWFT=0 data one cycle after read accept; FWFT=1 head visible the cycle after write.
// Backpressure: writes refused while full, reads refused while empty (flags registered).
//
// Ports: clk, rst_n (async active-low), clr (sync flush),
//        w_en/data_in (write), r_en/data_out (read or pop in FWFT mode),
//        full/empty/almost_full/almost_empty/count (status),
//        overflow/underflow (sticky errors, cleared by clr or reset).
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      w_en,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      r_en,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

  // Elaboration-time legality check of the parameter set.
  if (!is_pow2(DEPTH) || DEPTH < 4 || DATA_WIDTH < 1 || AE_LEVEL < 0 ||
      AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_param_err
    $error("param_sync_fifo: illegal parameters DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           DEPTH, AF_LEVEL, AE_LEVEL);
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q,  count_d;
  logic                  full_q,   full_d;
  logic                  empty_q,  empty_d;
  logic                  af_q,     af_d;
  logic                  ae_q,     ae_d;
  logic                  ovf_q,    ovf_d;
  logic                  unf_q,    unf_d;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    // Acceptance uses the registered flags, so a full FIFO still takes a
    // read and an empty FIFO still takes a write in the same cycle.
    wr_acc   = w_en && !full_q  && !clr;
    rd_acc   = r_en && !empty_q && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      if (w_en && full_q) ovf_d = 1'b1;
      // A read against an empty FIFO that is being written the same cycle is
      // a harmless collision, not a lost read, so it does not flag underflow.
      if (r_en && empty_q && !w_en) unf_d = 1'b1;
    end

    // Every status bit is derived from the next pointers so all of them move
    // together with count on the same edge.
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head slot is always presented; r_en only advances the read pointer.
    assign data_out = rdata;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q;

    // Holds the last accepted word until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= rdata;
      end
    end

    assign data_out = dout_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Purpose: randomized scoreboard bench for param_sync_fifo (registered and FWFT builds).
// Latency: expected read data is queued when a read is issued and matched one cycle later.
// Backpressure: the reference model decides acceptance from its own occupancy.
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clr, w_en, r_en;
  logic [DW-1:0] data_in, data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  logic          f_clr, f_w_en, f_r_en;
  logic [DW-1:0] f_data_in, f_data_out;
  logic          f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [CW-1:0] f_count;

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst_n(rst_n), .clr(f_clr), .w_en(f_w_en), .data_in(f_data_in), .r_en(f_r_en),
    .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: a plain queue of stored words plus sticky flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] fq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count",        32'(count),        32'(mq.size()));
    chk("full",         32'(full),         32'(mq.size() == DEPTH));
    chk("empty",        32'(empty),        32'(mq.size() == 0));
    chk("almost_full",  32'(almost_full),  32'(mq.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_unf));
    chk("data_out",     32'(data_out),     32'(m_dout));
  endtask

  // Checks the effect of the previous cycle, then issues one new cycle of
  // stimulus and advances the model to where the DUT should be after it.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    int sz;
    @(posedge clk); #1;
    check_state();
    w_en = w; data_in = d; r_en = r; clr = c;
    sz = mq.size();
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0 && !w) m_unf = 1'b1;
      if (r && sz > 0) begin
        m_dout = mq.pop_front();
        exp_q.push_back(m_dout);
      end
      if (w && sz < DEPTH) mq.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    w_en = 1'b0; r_en = 1'b0; clr = 1'b0; data_in = '0;
    mq.delete(); exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    #1;
    check_state();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Scoreboard monitor: a read seen accepted at one negedge must present
  // the oldest expected word at the next negedge.
  bit            pend = 1'b0;
  logic [DW-1:0] mon_exp;
  always @(negedge clk) begin
    if (pend && rst_n) begin
      cmp_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL sb_unexpected_read: got 0x%0h, expected no read at %0t", data_out, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_out !== mon_exp) begin
          err_cnt++;
          $display("FAIL sb_data: got 0x%0h, expected 0x%0h at %0t", data_out, mon_exp, $time);
        end
      end
    end
    pend = rst_n && r_en && !empty && !clr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    f_clr = 1'b0; f_w_en = 1'b0; f_r_en = 1'b0; f_data_in = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;

    do_reset();

    // Fill to full with 0x01..0x10, then one write too many.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    // Drain in order, then one read too many.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read+write at full, then at empty.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush with a concurrent write, then new traffic.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Alternating write/read.
    for (int c = 0; c < 60; c++) begin
      step(c % 2 == 0, 8'($urandom), c % 2 == 1, 1'b0);
      chk("alt_count_le1", 32'(count <= 1), 32'd1);
    end

    // Random traffic: write-heavy phase, then read-heavy phase, rare flushes.
    for (int i = 0; i < 200; i++)
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0, ($urandom % 64) == 0);
    for (int i = 0; i < 200; i++)
      step(($urandom % 4) == 0, 8'($urandom), ($urandom % 4) != 0, ($urandom % 64) == 0);

    // Reset with data buffered; the first read must return post-reset data.
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'h6B, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // First-word-fall-through build.
    chk("fwft_reset_empty", 32'(f_empty), 32'd1);
    chk("fwft_reset_count", 32'(f_count), 32'd0);
    @(posedge clk); #1;
    f_w_en = 1'b1; f_data_in = 8'hA5;
    @(posedge clk); #1;
    f_w_en = 1'b0;
    chk("fwft_first_word", 32'(f_data_out), 32'hA5);
    chk("fwft_not_empty",  32'(f_empty),    32'd0);
    chk("fwft_count1",     32'(f_count),    32'd1);
    @(posedge clk); #1;
    chk("fwft_hold_no_ren", 32'(f_data_out), 32'hA5);
    f_r_en = 1'b1;
    @(posedge clk); #1;
    f_r_en = 1'b0;
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);
    chk("fwft_pop_count", 32'(f_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      f_w_en = 1'b1; f_data_in = 8'($urandom);
      fq.push_back(f_data_in);
      @(posedge clk); #1;
    end
    f_w_en = 1'b0;
    while (fq.size() > 0) begin
      chk("fwft_head", 32'(f_data_out), 32'(fq.pop_front()));
      f_r_en = 1'b1;
      @(posedge clk); #1;
      f_r_en = 1'b0;
    end
    chk("fwft_drained_empty", 32'(f_empty), 32'd1);
    chk("fwft_no_underflow",  32'(f_underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 DATA_WIDTH, 8, data bits per entry (>=1).
REQ-002 DEPTH, 16, number of entries; power of two, >=4.
REQ-003 AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 FWFT, 0, 0 = registered read (data one cycle after accept); 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 clr  input  1  synchronous flush; empties FIFO, clears sticky flags.
REQ-009 w_en  input  1  write request.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 r_en  input  1  read request (FWFT=1: pop/acknowledge of head).
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 full / empty  output  1 each  status, registered.
REQ-014 almost_full / almost_empty  output  1 each  threshold status.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accepted iff w_en && !full; rejected write leaves storage and pointers unchanged.
REQ-018 Read accepted iff r_en && !empty; rejected read leaves data_out unchanged.
REQ-019 Pointers $clog2(DEPTH)+1 bits; extra MSB distinguishes full from empty on wrap-around.
REQ-020 full when pointers differ only in MSB; empty when pointers equal; both updated same edge as accept.
REQ-021 count increments on write-only, decrements on read-only, holds on simultaneous accepted read+write.
REQ-022 When full, simultaneous w_en+r_en: read accepted, write rejected, count = DEPTH-1 next cycle.
REQ-023 When empty, simultaneous w_en+r_en: write accepted, read rejected, count = 1 next cycle.
REQ-024 FWFT=0: data_out registers head entry on the edge a read is accepted; valid from that edge until next accepted read.
REQ-025 FWFT=1: data_out shows head entry combinationally from storage whenever !empty; first write visible the cycle after it is accepted; r_en pops.
REQ-026 overflow sets on w_en && full; underflow sets on r_en && empty; both hold until clr or reset.
REQ-027 clr has priority over w_en/r_en same cycle: pointers, count, flags cleared; storage contents not cleared.
REQ-028 almost_full/almost_empty derived from count next-state, registered, coherent with count every cycle.
REQ-029 Data ordering strictly first-in first-out across any number of pointer wraps.

Reset
REQ-030 On rst_n low: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, data_out 0 (FWFT=0).
REQ-031 Reset mid-operation discards all buffered entries; first read after release returns first post-reset write.
REQ-032 Storage array not reset.

Structure
REQ-033 Package fifo_pkg holds pointer-width function and default DATA_WIDTH/DEPTH constants.
REQ-034 One sub-module fifo_mem: DEPTH x DATA_WIDTH register array, one write port, one async read port.
REQ-035 Parameter legality (power-of-two DEPTH, AE_LEVEL < AF_LEVEL <= DEPTH) checked at elaboration.

Verification
REQ-036 Reset, then write 16 values 0x01..0x10 (DEPTH=16) -> full=1 after 16th, count=16, almost_full from count 14; 17th write -> overflow=1, data kept.
REQ-037 Read 16 from full -> data_out 0x01..0x10 in order, empty=1 after last; extra read -> underflow=1, data_out holds 0x10.
REQ-038 Alternating write/read on odd/even cycles, 60 cycles, random data -> scoreboard match, count never exceeds 1.
REQ-039 Full + simultaneous w_en/r_en -> count 15, oldest entry out; empty + both -> count 1, no underflow.
REQ-040 Write 5 entries, assert clr with w_en -> count 0, empty 1, flags 0; next write/read returns new data.
REQ-041 FWFT=1: write 0xA5 to empty -> data_out 0xA5 next cycle with no r_en; r_en pops, empty=1.
